// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with 2-bit saturating direction
// counters. Lookup is combinational on fetch_pc_i; training happens on the
// rising edge from one resolved control-flow instruction per cycle.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update to a lookup of the
// same index so tight loops do not see a one-cycle stale prediction.
module branch_target_buffer #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc_i,
   output logic        btb_hit,
   output logic [31:0] btb_pre_pc,
   output logic        predict_taken,
   input  logic        execute_valid_i,
   input  logic [31:0] execute_pc_i,
   input  logic        execute_is_branch_i,
   input  logic        execute_is_jump_i,
   input  logic        execute_branch_jump_i,
   input  logic [31:0] execute_target_i
);

   localparam int ENTRIES = 1 << IDX_W;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [TAG_W-1:0] tag_t;

   // ctr: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken
   typedef struct packed {
      logic        valid;
      tag_t        tag;
      logic [31:0] target;
      logic [1:0]  ctr;
   } entry_t;

   logic        valid_q  [ENTRIES];
   logic [1:0]  ctr_q    [ENTRIES];
   tag_t        tag_q    [ENTRIES];
   logic [31:0] target_q [ENTRIES];

   idx_t   ex_idx;
   tag_t   ex_tag;
   entry_t ex_old;
   logic   ex_match;
   entry_t entry_d;
   logic   upd_we;

   idx_t   f_idx;
   tag_t   f_tag;
   entry_t look;
   logic   hit;

   logic   unused_bits;

   // Decide whether the resolved instruction modifies its entry, and with what
   always_comb begin
      // NOTE: every output of this block gets a default before any branch so
      // no path leaves a value unassigned; that is what keeps it latch-free.
      ex_idx   = execute_pc_i[IDX_W+1:2];
      ex_tag   = execute_pc_i[IDX_W+1+TAG_W:IDX_W+2];
      ex_old.valid  = valid_q[ex_idx];
      ex_old.tag    = tag_q[ex_idx];
      ex_old.target = target_q[ex_idx];
      ex_old.ctr    = ctr_q[ex_idx];
      ex_match = ex_old.valid && (ex_old.tag == ex_tag);
      entry_d  = ex_old;
      upd_we   = 1'b0;
      if (!rst && execute_valid_i) begin
         if (execute_is_branch_i) begin
            if (ex_match) begin
               upd_we = 1'b1;
               if (execute_branch_jump_i) begin
                  entry_d.ctr    = (ex_old.ctr == 2'b11) ? 2'b11 : ex_old.ctr + 2'd1;
                  entry_d.target = execute_target_i;
               end else begin
                  entry_d.ctr    = (ex_old.ctr == 2'b00) ? 2'b00 : ex_old.ctr - 2'd1;
               end
            end else if (execute_branch_jump_i) begin
               // Allocate: a taken branch evicts whatever occupied the slot
               upd_we         = 1'b1;
               entry_d.valid  = 1'b1;
               entry_d.tag    = ex_tag;
               entry_d.target = execute_target_i;
               entry_d.ctr    = 2'b10;
            end
         end else if (execute_is_jump_i) begin
            upd_we         = 1'b1;
            entry_d.valid  = 1'b1;
            entry_d.tag    = ex_tag;
            entry_d.target = execute_target_i;
            entry_d.ctr    = 2'b11;
         end
      end
   end

   // Valid bits and counters: cleared on reset, written on an applied update
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (upd_we) begin
         valid_q[ex_idx] <= entry_d.valid;
         ctr_q[ex_idx]   <= entry_d.ctr;
      end
   end

   // Tag and target payload: written on update only
   always_ff @(posedge clk) begin
      // NOTE: payload arrays carry no reset; a cleared valid bit already hides
      // them, and leaving reset off lets them map onto plain RAM.
      if (upd_we) begin
         tag_q[ex_idx]    <= entry_d.tag;
         target_q[ex_idx] <= entry_d.target;
      end
   end

   // Combinational lookup on the fetch PC, optionally forwarding this cycle's update
   always_comb begin
      f_idx       = fetch_pc_i[IDX_W+1:2];
      f_tag       = fetch_pc_i[IDX_W+1+TAG_W:IDX_W+2];
      look.valid  = valid_q[f_idx];
      look.tag    = tag_q[f_idx];
      look.target = target_q[f_idx];
      look.ctr    = ctr_q[f_idx];
`ifdef BTB_BYPASS_EN
      if (upd_we && (ex_idx == f_idx)) begin
         look = entry_d;
      end
`endif
      hit           = !rst && look.valid && (look.tag == f_tag);
      btb_hit       = hit;
      predict_taken = hit && look.ctr[1];
      btb_pre_pc    = hit ? look.target : 32'h0;
   end

   // Byte-offset PC bits and the weak/strong counter bit never steer the lookup
   assign unused_bits = ^{fetch_pc_i, execute_pc_i, look.ctr[0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer. Each cycle's expected lookup
// result is pushed to a scoreboard when stimulus is applied and popped and
// compared on the falling edge, after the combinational lookup has settled.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc_i;
   logic        btb_hit;
   logic [31:0] btb_pre_pc;
   logic        predict_taken;
   logic        execute_valid_i;
   logic [31:0] execute_pc_i;
   logic        execute_is_branch_i;
   logic        execute_is_jump_i;
   logic        execute_branch_jump_i;
   logic [31:0] execute_target_i;

   typedef struct packed {
      logic        hit;
      logic        taken;
      logic [31:0] pc;
   } exp_t;

   exp_t  sb_q[$];
   string name_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   localparam logic [31:0] PC_A   = 32'h8000_0010; // idx 4
   localparam logic [31:0] PC_J   = 32'h8000_0050; // idx 4, different tag
   localparam logic [31:0] PC_NT  = 32'h8000_0020; // idx 8
   localparam logic [31:0] PC_S   = 32'h8000_0030; // idx 12
   localparam logic [31:0] PC_IDL = 32'h0000_0000; // idx 0, never allocated

   branch_target_buffer dut (
      .clk                   (clk),
      .rst                   (rst),
      .fetch_pc_i            (fetch_pc_i),
      .btb_hit               (btb_hit),
      .btb_pre_pc            (btb_pre_pc),
      .predict_taken         (predict_taken),
      .execute_valid_i       (execute_valid_i),
      .execute_pc_i          (execute_pc_i),
      .execute_is_branch_i   (execute_is_branch_i),
      .execute_is_jump_i     (execute_is_jump_i),
      .execute_branch_jump_i (execute_branch_jump_i),
      .execute_target_i      (execute_target_i)
   );

   always #5 clk = ~clk;

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic br,
                          input logic jmp, input logic tkn, input logic [31:0] tgt);
      execute_valid_i       = v;
      execute_pc_i          = pc;
      execute_is_branch_i   = br;
      execute_is_jump_i     = jmp;
      execute_branch_jump_i = tkn;
      execute_target_i      = tgt;
   endtask

   task automatic idle();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // One cycle: present fetch PC, queue its expectation, score at negedge
   task automatic step(input logic [31:0] fpc, input logic eh, input logic et,
                       input logic [31:0] ep, input string nm);
      exp_t  e;
      string n;
      fetch_pc_i = fpc;
      sb_q.push_back('{hit: eh, taken: et, pc: ep});
      name_q.push_back(nm);
      @(negedge clk);
      e = sb_q.pop_front();
      n = name_q.pop_front();
      n_cmp++;
      if (btb_hit !== e.hit) begin
         n_bad++;
         $display("FAIL %s btb_hit: got %b want %b", n, btb_hit, e.hit);
      end
      n_cmp++;
      if (predict_taken !== e.taken) begin
         n_bad++;
         $display("FAIL %s predict_taken: got %b want %b", n, predict_taken, e.taken);
      end
      n_cmp++;
      if (btb_pre_pc !== e.pc) begin
         n_bad++;
         $display("FAIL %s btb_pre_pc: got %h want %h", n, btb_pre_pc, e.pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step(PC_A, 1'b0, 1'b0, 32'h0, "reset_active");
      rst = 1'b0;
      step(PC_A, 1'b0, 1'b0, 32'h0, "after_reset");
   endtask

   task automatic test_allocate();
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b1, 32'h8000_0000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "alloc_cycle");
      idle();
      step(PC_A, 1'b1, 1'b1, 32'h8000_0000, "alloc_hit");
   endtask

   task automatic test_counter();
      // ctr 10 -> 01
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b0, 32'h0);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "nt1_upd");
      idle();
      step(PC_A, 1'b1, 1'b0, 32'h8000_0000, "ctr_01");
      // 01 -> 00 -> 00 (low saturation)
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b0, 32'h0);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "nt2_upd");
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "nt3_upd");
      idle();
      step(PC_A, 1'b1, 1'b0, 32'h8000_0000, "ctr_00");
      // 00 -> 01: still not taken if the counter did not wrap
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b1, 32'h8000_0000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "t1_upd");
      idle();
      step(PC_A, 1'b1, 1'b0, 32'h8000_0000, "ctr_01_from_00");
      // 01 -> 10
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b1, 32'h8000_0000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "t2_upd");
      idle();
      step(PC_A, 1'b1, 1'b1, 32'h8000_0000, "ctr_10");
      // 10 -> 11 -> 11 (high saturation), then one NT -> 10 still taken
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b1, 32'h8000_0000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "t3_upd");
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "t4_upd");
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b0, 32'h0);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "nt4_upd");
      idle();
      step(PC_A, 1'b1, 1'b1, 32'h8000_0000, "ctr_sat_11");
      // Taken on a match retargets; not-taken leaves the target alone
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b1, 32'h8000_0200);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "retarget_upd");
      set_upd(1'b1, PC_A, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEC);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "nt_keep_tgt_upd");
      idle();
      step(PC_A, 1'b1, 1'b1, 32'h8000_0200, "retarget_hit");
   endtask

   task automatic test_jump();
      set_upd(1'b1, PC_J, 1'b0, 1'b1, 1'b0, 32'h8000_1000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "jump_upd");
      idle();
      step(PC_J, 1'b1, 1'b1, 32'h8000_1000, "jump_hit");
      step(PC_A, 1'b0, 1'b0, 32'h0, "evicted_miss");
      step(32'h8000_0090, 1'b0, 1'b0, 32'h0, "alias_miss");
   endtask

   task automatic test_ignored();
      // Branch+jump both set, not taken: treated as a branch, no allocation
      set_upd(1'b1, 32'h8000_0040, 1'b1, 1'b1, 1'b0, 32'h8000_3000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "br_jmp_nt_upd");
      set_upd(1'b1, PC_NT, 1'b1, 1'b0, 1'b0, 32'h8000_4000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "nt_noalloc_upd");
      set_upd(1'b1, 32'h8000_0060, 1'b0, 1'b0, 1'b1, 32'h8000_5000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "no_type_upd");
      set_upd(1'b0, 32'h8000_0070, 1'b1, 1'b0, 1'b1, 32'h8000_6000);
      step(PC_IDL, 1'b0, 1'b0, 32'h0, "invalid_upd");
      idle();
      step(32'h8000_0040, 1'b0, 1'b0, 32'h0, "br_jmp_nt_miss");
      step(PC_NT, 1'b0, 1'b0, 32'h0, "nt_noalloc_miss");
      step(32'h8000_0060, 1'b0, 1'b0, 32'h0, "no_type_miss");
      step(32'h8000_0070, 1'b0, 1'b0, 32'h0, "invalid_miss");
   endtask

   task automatic test_same_cycle();
      set_upd(1'b1, PC_S, 1'b1, 1'b0, 1'b1, 32'h8000_2000);
`ifdef BTB_BYPASS_EN
      step(PC_S, 1'b1, 1'b1, 32'h8000_2000, "same_cycle_bypass");
`else
      step(PC_S, 1'b0, 1'b0, 32'h0, "same_cycle_stale");
`endif
      idle();
      step(PC_S, 1'b1, 1'b1, 32'h8000_2000, "same_cycle_next");
   endtask

   task automatic test_reset_override();
      rst = 1'b1;
      set_upd(1'b1, 32'h8000_0080, 1'b0, 1'b1, 1'b1, 32'h8000_7000);
      step(32'h8000_0080, 1'b0, 1'b0, 32'h0, "rst_with_upd");
      rst = 1'b0;
      idle();
      step(32'h8000_0080, 1'b0, 1'b0, 32'h0, "rst_upd_dropped");
      step(PC_S, 1'b0, 1'b0, 32'h0, "rst_cleared_S");
      step(PC_J, 1'b0, 1'b0, 32'h0, "rst_cleared_J");
   endtask

   initial begin
      rst        = 1'b1;
      fetch_pc_i = 32'h0;
      idle();
      @(posedge clk);
      #1;
      test_reset();
      test_allocate();
      test_counter();
      test_jump();
      test_ignored();
      test_same_cycle();
      test_reset_override();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped, tagged BTB with 2-bit saturating direction counters.
- Sits directly upstream of the next-PC selector and drives its `btb_hit`, `btb_pre_pc` and `predict_taken` inputs from a combinational lookup on the current fetch PC.
- Trained once per resolved control-flow instruction from the execute stage.
- State updates on the clock edge; the lookup path is purely combinational from stored state.

Parameters:
- IDX_W, 4, index width; the table holds 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, 26, tag width; the tag is pc[IDX_W+1+TAG_W:IDX_W+2]. Default covers all of pc[31:6].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- fetch_pc_i  input  32  PC being fetched this cycle; bits [1:0] ignored.
- btb_hit  output  1  valid entry with matching tag for fetch_pc_i.
- btb_pre_pc  output  32  stored target on hit; 32'h0 on miss.
- predict_taken  output  1  btb_hit & counter[1].
- execute_valid_i  input  1  update strobe; one resolved control-flow instruction this cycle.
- execute_pc_i  input  32  PC of the resolved instruction.
- execute_is_branch_i  input  1  conditional branch.
- execute_is_jump_i  input  1  unconditional jump (jal/jalr); ignored if is_branch is also set.
- execute_branch_jump_i  input  1  actual outcome taken.
- execute_target_i  input  32  actual target address.

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (32), ctr (2). ctr encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (rst=1 at posedge):
  - All valid cleared; all ctr set to 01; tag and target need not be cleared.
  - While and after reset, btb_hit=0, predict_taken=0, btb_pre_pc=0.
  - rst overrides any same-cycle update.
- Lookup (0-cycle, combinational):
  - idx = fetch_pc_i[IDX_W+1:2].
  - hit = valid[idx] & (tag[idx] == fetch tag).
  - Outputs gated by hit as defined in Ports.
- Update, at posedge when execute_valid_i=1 and (is_branch | is_jump). idx and tag are taken from execute_pc_i; "match" means valid & tag equal.
  - Conditional branch, match:
    - ctr saturating +1 if taken, -1 if not; no wrap (11+1 stays 11, 00-1 stays 00).
    - If taken, target <= execute_target_i.
  - Conditional branch, no match, taken: allocate. valid=1, tag, target, ctr=10; evicts any previous occupant.
  - Conditional branch, no match, not taken: no state change.
  - Jump, any hit state: valid=1, tag, target written, ctr=11.
- Ignored updates:
  - execute_valid_i=0, or neither is_branch nor is_jump: no state change.
  - Inputs other than rst are don't-care while execute_valid_i=0.
- At most one entry is modified per cycle.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; the new contents are visible from the next cycle. Overridden by the optional feature below.
- Aliasing: a different PC with the same idx and a different tag misses; it is replaced only through the allocation rules above.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: when an update is applied this cycle and its idx equals the lookup idx, the lookup sees the post-update entry (valid, tag, target, ctr) in the same cycle. This removes one-cycle stale predictions for tight loops. The bypass is suppressed while rst=1.
- Undefined: no bypass; lookup always reads registered state.

Test Plan:
- Reset, then fetch_pc_i=0x8000_0010 -> btb_hit=0, predict_taken=0, btb_pre_pc=0.
- Update: branch at 0x8000_0010, taken, target 0x8000_0000. Next cycle fetch 0x8000_0010 -> hit=1, predict_taken=1, btb_pre_pc=0x8000_0000.
- Same branch resolved not-taken 2x (ctr 10->01->00), then one taken (ctr 01) -> predict_taken=0, hit=1. Two further takens -> ctr 11. One more taken -> ctr stays 11.
- Jump at 0x8000_0050 (idx 4, tag differs from 0x8000_0010), target 0x8000_1000 -> fetch 0x8000_0050 hits with predict_taken=1. Fetch 0x8000_0010 now misses (evicted).
- Not-taken branch at 0x8000_0020 with no entry -> subsequent fetch of 0x8000_0020 misses; no allocation.
- Update and fetch of 0x8000_0030 in the same cycle:
  - Without BTB_BYPASS_EN: hit=0 that cycle, 1 the next.
  - With BTB_BYPASS_EN: hit=1 that cycle.
  - Update with rst=1: no entry written.
